lsu_axi_ctrl: RTL and testbench

LSU_AXI_CTRL -- requirements
Module: lsu_axi_ctrl

---
 rtl/lsu_axi_ctrl_pkg.sv | 41 ++++
 rtl/lsu_lane_align.sv | 60 ++++++
 rtl/lsu_axi_ctrl.sv | 177 +++++++++++++++++
 tb/tb_lsu_axi_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_axi_ctrl_pkg.sv
// Shared definitions for the load/store unit AXI controller: FSM states,
// operation, access-size and error codes, plus the alignment check.
package lsu_axi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS      = 2'b10;

    // An access is misaligned when the address is not a multiple of its size;
    // doubleword accesses are also rejected on a bus too narrow to carry them.
    function automatic logic is_misaligned(input logic [2:0] addr_low,
                                           input logic [1:0] size,
                                           input logic       dword_ok);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = addr_low[0];
            SZ_WORD: is_misaligned = |addr_low[1:0];
            default: is_misaligned = (|addr_low) || !dword_ok;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: places store data and strobes on the lanes selected by
// the address offset, and extracts/extends load data from those lanes.
module lsu_lane_align
    import lsu_axi_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8,
    parameter int OFF_W  = $clog2(STRB_W)
) (
    input  logic [OFF_W-1:0]  offset,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] lane_wdata,
    output logic [STRB_W-1:0] lane_wstrb,
    input  logic [DATA_W-1:0] load_raw,
    output logic [DATA_W-1:0] load_data
);

    logic [STRB_W-1:0] base_strb;
    logic [DATA_W-1:0] shifted;
    logic              sign_bit;
    int                keep;

    assign lane_wdata = store_data << {offset, 3'b000};
    assign lane_wstrb = base_strb << offset;
    assign shifted    = load_raw >> {offset, 3'b000};

    // One strobe bit per byte of the access, before lane shifting.
    always_comb begin
        case (size)
            SZ_BYTE: base_strb = STRB_W'(1'b1);
            SZ_HALF: base_strb = STRB_W'(2'b11);
            SZ_WORD: base_strb = STRB_W'(4'hF);
            default: base_strb = '1;
        endcase
    end

    // Keep the low bytes of the access and fill the rest with sign or zero.
    always_comb begin
        keep     = DATA_W;
        sign_bit = shifted[DATA_W-1];
        case (size)
            SZ_BYTE: begin keep = 8;  sign_bit = shifted[7];  end
            SZ_HALF: begin keep = 16; sign_bit = shifted[15]; end
            SZ_WORD: begin keep = 32; sign_bit = shifted[31]; end
            default: begin keep = DATA_W; sign_bit = shifted[DATA_W-1]; end
        endcase
        if (is_unsigned) begin
            sign_bit = 1'b0;
        end
        load_data = shifted;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= keep) begin
                load_data[i] = sign_bit;
            end
        end
    end

endmodule

// File: rtl/lsu_axi_ctrl.sv
// Load/store unit front end: accepts one memory request at a time, runs it as
// a single AXI read or write transaction and returns the aligned result.
module lsu_axi_ctrl
    import lsu_axi_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_pre_i,
    output logic              ready_pre_o,
    input  logic [1:0]        op_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              valid_post_o,
    input  logic              ready_post_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        err_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o
);

    localparam int OFF_W = $clog2(STRB_W);

    state_t            state, next_state;
    logic [1:0]        op_q, size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              aw_done, w_done;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] load_ext;
    logic              misaligned, no_op, accept;
    logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign misaligned = is_misaligned(addr_i[2:0], size_i, DATA_W == 64);
    assign no_op      = (op_i == OP_NONE) || (op_i == OP_RSVD);
    assign accept     = (state == ST_IDLE) && valid_pre_i;
    assign ar_hs      = arvalid_o && arready_i;
    assign r_hs       = rvalid_i && rready_o;
    assign aw_hs      = awvalid_o && awready_i;
    assign w_hs       = wvalid_o && wready_i;
    assign b_hs       = bvalid_i && bready_o;

    lsu_lane_align #(
        .DATA_W (DATA_W),
        .STRB_W (STRB_W),
        .OFF_W  (OFF_W)
    ) u_lane_align (
        .offset      (addr_q[OFF_W-1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .store_data  (wdata_q),
        .lane_wdata  (wdata_o),
        .lane_wstrb  (wstrb_o),
        .load_raw    (rdata_i),
        .load_data   (load_ext)
    );

    // State register; reset drops any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection from the current state and channel handshakes.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (valid_pre_i) begin
                    if (no_op || misaligned) begin
                        next_state = ST_DONE;
                    end else if (op_i == OP_LOAD) begin
                        next_state = ST_RD_ADDR;
                    end else begin
                        next_state = ST_WR_REQ;
                    end
                end
            end
            ST_RD_ADDR: if (ar_hs) next_state = ST_RD_DATA;
            ST_RD_DATA: if (r_hs) next_state = ST_DONE;
            ST_WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) next_state = ST_WR_RESP;
            ST_WR_RESP: if (b_hs) next_state = ST_DONE;
            ST_DONE:    if (ready_post_i) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Handshake and address outputs decoded from registered state only.
    always_comb begin
        ready_pre_o  = (state == ST_IDLE);
        arvalid_o    = (state == ST_RD_ADDR);
        rready_o     = (state == ST_RD_DATA);
        awvalid_o    = (state == ST_WR_REQ) && !aw_done;
        wvalid_o     = (state == ST_WR_REQ) && !w_done;
        bready_o     = (state == ST_WR_RESP);
        valid_post_o = (state == ST_DONE);
        araddr_o     = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        awaddr_o     = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        rdata_o      = rdata_q;
        err_o        = err_q;
    end

    // Request capture, write-channel progress flags and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= OP_NONE;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            if (accept) begin
                op_q    <= op_i;
                size_q  <= size_i;
                uns_q   <= unsigned_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (no_op) begin
                    err_q   <= ERR_OK;
                    rdata_q <= '0;
                end else if (misaligned) begin
                    err_q   <= ERR_MISALIGN;
                    rdata_q <= '0;
                end
            end
            if (state == ST_WR_REQ) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if ((state == ST_RD_DATA) && r_hs) begin
                if (rresp_i != 2'b00) begin
                    err_q   <= ERR_BUS;
                    rdata_q <= '0;
                end else begin
                    err_q   <= ERR_OK;
                    rdata_q <= load_ext;
                end
            end
            if ((state == ST_WR_RESP) && b_hs) begin
                err_q   <= (bresp_i != 2'b00) ? ERR_BUS : ERR_OK;
                rdata_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// Directed testbench for lsu_axi_ctrl: a table of single transactions served
// by a reactive AXI slave, followed by hand-written multi-cycle sequences.
module tb_lsu_axi_ctrl;
    import lsu_axi_ctrl_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int NV     = 16;

    logic              clk, rst;
    logic              valid_pre_i, ready_pre_o;
    logic [1:0]        op_i, size_i;
    logic              unsigned_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              valid_post_o, ready_post_i;
    logic [DATA_W-1:0] rdata_o;
    logic [1:0]        err_o;
    logic [ADDR_W-1:0] araddr_o, awaddr_o;
    logic              arvalid_o, arready_i;
    logic [DATA_W-1:0] rdata_i;
    logic [1:0]        rresp_i;
    logic              rvalid_i, rready_o;
    logic              awvalid_o, awready_i;
    logic [DATA_W-1:0] wdata_o;
    logic [STRB_W-1:0] wstrb_o;
    logic              wvalid_o, wready_i;
    logic [1:0]        bresp_i;
    logic              bvalid_i, bready_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_err;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        int          exp_ar;
        int          exp_w;
    } vec_t;

    vec_t vecs [NV];

    lsu_axi_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_pre_i  (valid_pre_i),
        .ready_pre_o  (ready_pre_o),
        .op_i         (op_i),
        .size_i       (size_i),
        .unsigned_i   (unsigned_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .valid_post_o (valid_post_o),
        .ready_post_i (ready_post_i),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .araddr_o     (araddr_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .rdata_i      (rdata_i),
        .rresp_i      (rresp_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .awaddr_o     (awaddr_o),
        .awvalid_o    (awvalid_o),
        .awready_i    (awready_i),
        .wdata_o      (wdata_o),
        .wstrb_o      (wstrb_o),
        .wvalid_o     (wvalid_o),
        .wready_i     (wready_i),
        .bresp_i      (bresp_i),
        .bvalid_i     (bvalid_i),
        .bready_o     (bready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic present_request(input logic [1:0] op, input logic [1:0] size,
                                   input logic uns, input logic [31:0] addr,
                                   input logic [31:0] wdata);
        valid_pre_i = 1'b1;
        op_i        = op;
        size_i      = size;
        unsigned_i  = uns;
        addr_i      = addr;
        wdata_i     = wdata;
        @(negedge clk);
        valid_pre_i = 1'b0;
    endtask

    task automatic release_result(input string name);
        rvalid_i     = 1'b0;
        bvalid_i     = 1'b0;
        arready_i    = 1'b0;
        awready_i    = 1'b0;
        wready_i     = 1'b0;
        ready_post_i = 1'b1;
        @(negedge clk);
        ready_post_i = 1'b0;
        check_output({name, "_post_drop"}, 64'(valid_post_o), 64'(0));
        check_output({name, "_back_idle"}, 64'(ready_pre_o), 64'(1));
    endtask

    // One table transaction against an always-ready, reactive AXI slave.
    task automatic apply_stimulus(input vec_t v);
        int ar_n, aw_n, w_n, cyc;
        logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
        logic [3:0]  seen_wstrb;
        ar_n = 0; aw_n = 0; w_n = 0; cyc = 0;
        seen_araddr = '0; seen_awaddr = '0; seen_wdata = '0; seen_wstrb = '0;
        check_output({v.name, "_ready_pre"}, 64'(ready_pre_o), 64'(1));
        present_request(v.op, v.size, v.uns, v.addr, v.wdata);
        while (!valid_post_o && cyc < 40) begin
            arready_i = 1'b1;
            awready_i = 1'b1;
            wready_i  = 1'b1;
            rvalid_i  = rready_o;
            rdata_i   = v.rdata;
            rresp_i   = v.resp;
            bvalid_i  = bready_o;
            bresp_i   = v.resp;
            if (arvalid_o) begin ar_n++; seen_araddr = araddr_o; end
            if (awvalid_o) begin aw_n++; seen_awaddr = awaddr_o; end
            if (wvalid_o)  begin w_n++;  seen_wdata = wdata_o; seen_wstrb = wstrb_o; end
            @(negedge clk);
            cyc++;
        end
        check_output({v.name, "_done"}, 64'(valid_post_o), 64'(1));
        check_output({v.name, "_err"}, 64'(err_o), 64'(v.exp_err));
        check_output({v.name, "_rdata"}, 64'(rdata_o), 64'(v.exp_rdata));
        check_output({v.name, "_ar_count"}, 64'(ar_n), 64'(v.exp_ar));
        check_output({v.name, "_aw_count"}, 64'(aw_n), 64'(v.exp_w));
        check_output({v.name, "_w_count"}, 64'(w_n), 64'(v.exp_w));
        if (v.exp_ar != 0) begin
            check_output({v.name, "_araddr"}, 64'(seen_araddr), 64'({v.addr[31:2], 2'b00}));
        end
        if (v.exp_w != 0) begin
            check_output({v.name, "_awaddr"}, 64'(seen_awaddr), 64'({v.addr[31:2], 2'b00}));
            check_output({v.name, "_wdata"}, 64'(seen_wdata), 64'(v.exp_wdata));
            check_output({v.name, "_wstrb"}, 64'(seen_wstrb), 64'(v.exp_wstrb));
        end
        if (v.exp_ar == 0 && v.exp_w == 0) begin
            check_output({v.name, "_latency"}, 64'(cyc), 64'(0));
        end
        release_result(v.name);
    endtask

    initial begin
        int cyc, stall, w_n, aw_n;
        logic r_hs_prev;

        vecs[0]  = '{"lw_1004",   OP_LOAD,  SZ_WORD,  1'b0, 32'h1004, 32'h0,        32'h8000_00FF, 2'b00, 32'h8000_00FF, ERR_OK,       32'h0,        4'h0, 1, 0};
        vecs[1]  = '{"lb_1003",   OP_LOAD,  SZ_BYTE,  1'b0, 32'h1003, 32'h0,        32'h8012_3456, 2'b00, 32'hFFFF_FF80, ERR_OK,       32'h0,        4'h0, 1, 0};
        vecs[2]  = '{"lbu_1003",  OP_LOAD,  SZ_BYTE,  1'b1, 32'h1003, 32'h0,        32'h8012_3456, 2'b00, 32'h0000_0080, ERR_OK,       32'h0,        4'h0, 1, 0};
        vecs[3]  = '{"lh_1002",   OP_LOAD,  SZ_HALF,  1'b0, 32'h1002, 32'h0,        32'h8001_1234, 2'b00, 32'hFFFF_8001, ERR_OK,       32'h0,        4'h0, 1, 0};
        vecs[4]  = '{"lhu_1000",  OP_LOAD,  SZ_HALF,  1'b1, 32'h1000, 32'h0,        32'h1234_F00D, 2'b00, 32'h0000_F00D, ERR_OK,       32'h0,        4'h0, 1, 0};
        vecs[5]  = '{"lb_1001",   OP_LOAD,  SZ_BYTE,  1'b0, 32'h1001, 32'h0,        32'h0000_7F00, 2'b00, 32'h0000_007F, ERR_OK,       32'h0,        4'h0, 1, 0};
        vecs[6]  = '{"sb_2001",   OP_STORE, SZ_BYTE,  1'b0, 32'h2001, 32'h0000_00AB, 32'h0,        2'b00, 32'h0,         ERR_OK,       32'h0000_AB00, 4'h2, 0, 1};
        vecs[7]  = '{"sh_2002",   OP_STORE, SZ_HALF,  1'b0, 32'h2002, 32'h0000_BEEF, 32'h0,        2'b00, 32'h0,         ERR_OK,       32'hBEEF_0000, 4'hC, 0, 1};
        vecs[8]  = '{"sw_2000",   OP_STORE, SZ_WORD,  1'b0, 32'h2000, 32'hDEAD_BEEF, 32'h0,        2'b00, 32'h0,         ERR_OK,       32'hDEAD_BEEF, 4'hF, 0, 1};
        vecs[9]  = '{"sw_2001",   OP_STORE, SZ_WORD,  1'b0, 32'h2001, 32'h1111_2222, 32'h0,        2'b00, 32'h0,         ERR_MISALIGN, 32'h0,        4'h0, 0, 0};
        vecs[10] = '{"lh_1001",   OP_LOAD,  SZ_HALF,  1'b0, 32'h1001, 32'h0,        32'h5555_AAAA, 2'b00, 32'h0,         ERR_MISALIGN, 32'h0,        4'h0, 0, 0};
        vecs[11] = '{"ld_1000",   OP_LOAD,  SZ_DWORD, 1'b0, 32'h1000, 32'h0,        32'h5555_AAAA, 2'b00, 32'h0,         ERR_MISALIGN, 32'h0,        4'h0, 0, 0};
        vecs[12] = '{"op_none",   OP_NONE,  SZ_WORD,  1'b0, 32'h1000, 32'h0,        32'h5555_AAAA, 2'b00, 32'h0,         ERR_OK,       32'h0,        4'h0, 0, 0};
        vecs[13] = '{"op_rsvd",   OP_RSVD,  SZ_WORD,  1'b0, 32'h1000, 32'h0,        32'h5555_AAAA, 2'b00, 32'h0,         ERR_OK,       32'h0,        4'h0, 0, 0};
        vecs[14] = '{"lw_rresp",  OP_LOAD,  SZ_WORD,  1'b0, 32'h1008, 32'h0,        32'h1234_5678, 2'b10, 32'h0,         ERR_BUS,      32'h0,        4'h0, 1, 0};
        vecs[15] = '{"sw_bresp",  OP_STORE, SZ_WORD,  1'b0, 32'h2004, 32'h1122_3344, 32'h0,        2'b11, 32'h0,         ERR_BUS,      32'h1122_3344, 4'hF, 0, 1};

        rst = 1'b0;
        valid_pre_i = 1'b0; op_i = OP_NONE; size_i = SZ_BYTE; unsigned_i = 1'b0;
        addr_i = '0; wdata_i = '0; ready_post_i = 1'b0;
        arready_i = 1'b0; rdata_i = '0; rresp_i = 2'b00; rvalid_i = 1'b0;
        awready_i = 1'b0; wready_i = 1'b0; bresp_i = 2'b00; bvalid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        check_output("rst_ready_pre", 64'(ready_pre_o), 64'(1));
        check_output("rst_valid_post", 64'(valid_post_o), 64'(0));
        check_output("rst_arvalid", 64'(arvalid_o), 64'(0));
        check_output("rst_rready", 64'(rready_o), 64'(0));
        check_output("rst_awvalid", 64'(awvalid_o), 64'(0));
        check_output("rst_wvalid", 64'(wvalid_o), 64'(0));
        check_output("rst_bready", 64'(bready_o), 64'(0));
        check_output("rst_err", 64'(err_o), 64'(0));
        check_output("rst_rdata", 64'(rdata_o), 64'(0));

        for (int i = 0; i < NV; i++) begin
            apply_stimulus(vecs[i]);
        end

        // lw 0x1004 with arready held off for three cycles.
        present_request(OP_LOAD, SZ_WORD, 1'b0, 32'h1004, 32'h0);
        cyc = 0; stall = 0; r_hs_prev = 1'b0;
        while (!valid_post_o && cyc < 30) begin
            if (arvalid_o) begin
                check_output("ar_hold_addr", 64'(araddr_o), 64'(32'h1004));
                if (stall < 3) begin
                    arready_i = 1'b0;
                    stall++;
                end else begin
                    arready_i = 1'b1;
                end
            end else begin
                arready_i = 1'b0;
            end
            rvalid_i  = rready_o;
            rdata_i   = 32'h8000_00FF;
            rresp_i   = 2'b00;
            r_hs_prev = rvalid_i && rready_o;
            @(negedge clk);
            cyc++;
        end
        check_output("ar_delay_done", 64'(valid_post_o), 64'(1));
        check_output("ar_delay_stalls", 64'(stall), 64'(3));
        check_output("ar_delay_post_latency", 64'(r_hs_prev), 64'(1));
        check_output("ar_delay_rdata", 64'(rdata_o), 64'(32'h8000_00FF));
        check_output("ar_delay_err", 64'(err_o), 64'(ERR_OK));
        release_result("ar_delay");

        // sh 0x2002 with wready two cycles ahead of awready.
        arready_i = 1'b0; awready_i = 1'b0; wready_i = 1'b1;
        present_request(OP_STORE, SZ_HALF, 1'b0, 32'h2002, 32'h0000_BEEF);
        cyc = 0; w_n = 0; aw_n = 0;
        while (!valid_post_o && cyc < 30) begin
            awready_i = (cyc >= 2);
            wready_i  = 1'b1;
            bvalid_i  = bready_o;
            bresp_i   = 2'b00;
            if (wvalid_o && wready_i) begin
                w_n++;
                check_output("w_first_wdata", 64'(wdata_o), 64'(32'hBEEF_0000));
                check_output("w_first_wstrb", 64'(wstrb_o), 64'(4'b1100));
            end
            if (awvalid_o && awready_i) begin
                aw_n++;
                check_output("w_first_awaddr", 64'(awaddr_o), 64'(32'h2000));
            end
            if (cyc == 1) begin
                check_output("w_first_wvalid_dropped", 64'(wvalid_o), 64'(0));
                check_output("w_first_awvalid_held", 64'(awvalid_o), 64'(1));
            end
            @(negedge clk);
            cyc++;
        end
        check_output("w_first_done", 64'(valid_post_o), 64'(1));
        check_output("w_first_w_handshakes", 64'(w_n), 64'(1));
        check_output("w_first_aw_handshakes", 64'(aw_n), 64'(1));
        check_output("w_first_err", 64'(err_o), 64'(ERR_OK));
        release_result("w_first");

        // Load with a bus error, result held while downstream stalls.
        present_request(OP_LOAD, SZ_WORD, 1'b0, 32'h1010, 32'h0);
        cyc = 0;
        while (!valid_post_o && cyc < 30) begin
            arready_i = 1'b1;
            rvalid_i  = rready_o;
            rdata_i   = 32'hDEAD_BEEF;
            rresp_i   = 2'b10;
            @(negedge clk);
            cyc++;
        end
        rvalid_i = 1'b0; arready_i = 1'b0;
        check_output("hold_done", 64'(valid_post_o), 64'(1));
        for (int k = 0; k < 4; k++) begin
            check_output("hold_valid_post", 64'(valid_post_o), 64'(1));
            check_output("hold_err", 64'(err_o), 64'(ERR_BUS));
            check_output("hold_rdata", 64'(rdata_o), 64'(0));
            @(negedge clk);
        end
        release_result("hold");

        // Reset while a store sits in WR_REQ, then a normal store.
        awready_i = 1'b0; wready_i = 1'b0;
        present_request(OP_STORE, SZ_WORD, 1'b0, 32'h3000, 32'hCAFE_F00D);
        check_output("rst_wr_awvalid_before", 64'(awvalid_o), 64'(1));
        check_output("rst_wr_wvalid_before", 64'(wvalid_o), 64'(1));
        @(negedge clk);
        check_output("rst_wr_awvalid_held", 64'(awvalid_o), 64'(1));
        rst = 1'b0;
        #1;
        check_output("rst_wr_awvalid", 64'(awvalid_o), 64'(0));
        check_output("rst_wr_wvalid", 64'(wvalid_o), 64'(0));
        check_output("rst_wr_valid_post", 64'(valid_post_o), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_wr_ready_pre", 64'(ready_pre_o), 64'(1));
        check_output("rst_wr_awvalid_after", 64'(awvalid_o), 64'(0));
        apply_stimulus(vecs[8]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
